// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: head/tail/count controller for a 2-wide circular reorder
// buffer. It grants up to two dispatch allocations and up to two in-order
// commits per cycle, and drives the per-entry write enables of the valid
// array (enqueue writes 0 = busy, commit/flush writes 1 = free).
// Grants, indices and write enables are combinational from state and inputs.
// Optional macro ROB_ALLOC_PARTIAL_ENQ_EN: when defined, enqueue may grant
// only the older slot if just one entry is free; when undefined, enqueue is
// all-or-nothing.
`timescale 1ns/1ps

module rob_alloc_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       enq_req_i,
  output logic [1:0]       enq_gnt_o,
  output logic [IDX_W-1:0] enq_idx1_o,
  output logic [IDX_W-1:0] enq_idx2_o,
  input  logic [1:0]       cmt_req_i,
  output logic [1:0]       cmt_gnt_o,
  output logic [IDX_W-1:0] cmt_idx1_o,
  output logic [IDX_W-1:0] cmt_idx2_o,
  input  logic             flush_i,
  output logic [DEPTH-1:0] enq1_we_o,
  output logic [DEPTH-1:0] enq2_we_o,
  output logic [DEPTH-1:0] cmt1_we_o,
  output logic [DEPTH-1:0] cmt2_we_o,
  output logic [IDX_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic [IDX_W:0]   w_free;
  logic             w_enq_req0;
  logic             w_enq_req1;
  logic             w_cmt_req0;
  logic             w_cmt_req1;
  logic [1:0]       w_n_enq_req;
  logic [1:0]       w_n_enq_gnt;
  logic [1:0]       w_n_cmt_gnt;

  // Qualify requests: the younger slot only counts when the older slot is set.
  always_comb begin
    w_enq_req0  = enq_req_i[0];
    w_enq_req1  = enq_req_i[0] & enq_req_i[1];
    w_cmt_req0  = cmt_req_i[0];
    w_cmt_req1  = cmt_req_i[0] & cmt_req_i[1];
    w_n_enq_req = {1'b0, w_enq_req0} + {1'b0, w_enq_req1};
    w_free      = (IDX_W+1)'(DEPTH) - r_count;
  end

  // Grant logic; commits are judged against the current count only, so a
  // commit never frees space for an enqueue in the same cycle.
  always_comb begin
    enq_gnt_o = 2'b00;
    cmt_gnt_o = 2'b00;
    if (!rst_n || flush_i) begin
      enq_gnt_o = 2'b00;
      cmt_gnt_o = 2'b00;
    end else begin
`ifdef ROB_ALLOC_PARTIAL_ENQ_EN
      enq_gnt_o[0] = w_enq_req0 & (w_free >= (IDX_W+1)'(1));
      enq_gnt_o[1] = w_enq_req1 & (w_free >= (IDX_W+1)'(2));
`else
      if (w_free >= (IDX_W+1)'(w_n_enq_req)) begin
        enq_gnt_o = {w_enq_req1, w_enq_req0};
      end else begin
        enq_gnt_o = 2'b00;
      end
`endif
      cmt_gnt_o[0] = w_cmt_req0 & (r_count >= (IDX_W+1)'(1));
      cmt_gnt_o[1] = w_cmt_req1 & (r_count >= (IDX_W+1)'(2));
    end
    w_n_enq_gnt = {1'b0, enq_gnt_o[0]} + {1'b0, enq_gnt_o[1]};
    w_n_cmt_gnt = {1'b0, cmt_gnt_o[0]} + {1'b0, cmt_gnt_o[1]};
  end

  // Entry indices; held at zero while reset is asserted.
  always_comb begin
    if (!rst_n) begin
      enq_idx1_o = {IDX_W{1'b0}};
      enq_idx2_o = {IDX_W{1'b0}};
      cmt_idx1_o = {IDX_W{1'b0}};
      cmt_idx2_o = {IDX_W{1'b0}};
    end else begin
      enq_idx1_o = r_tail;
      enq_idx2_o = r_tail + IDX_W'(1);
      cmt_idx1_o = r_head;
      cmt_idx2_o = r_head + IDX_W'(1);
    end
  end

  // One-hot write enables for the valid array; flush frees every entry.
  always_comb begin
    enq1_we_o = {DEPTH{1'b0}};
    enq2_we_o = {DEPTH{1'b0}};
    cmt1_we_o = {DEPTH{1'b0}};
    cmt2_we_o = {DEPTH{1'b0}};
    if (!rst_n) begin
      cmt1_we_o = {DEPTH{1'b0}};
    end else if (flush_i) begin
      cmt1_we_o = {DEPTH{1'b1}};
    end else begin
      if (enq_gnt_o[0]) enq1_we_o = DEPTH'(1) << enq_idx1_o;
      else              enq1_we_o = {DEPTH{1'b0}};
      if (enq_gnt_o[1]) enq2_we_o = DEPTH'(1) << enq_idx2_o;
      else              enq2_we_o = {DEPTH{1'b0}};
      if (cmt_gnt_o[0]) cmt1_we_o = DEPTH'(1) << cmt_idx1_o;
      else              cmt1_we_o = {DEPTH{1'b0}};
      if (cmt_gnt_o[1]) cmt2_we_o = DEPTH'(1) << cmt_idx2_o;
      else              cmt2_we_o = {DEPTH{1'b0}};
    end
  end

  // Pointer and occupancy update; grants keep count within 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {IDX_W{1'b0}};
      r_tail  <= {IDX_W{1'b0}};
      r_count <= {(IDX_W+1){1'b0}};
    end else if (flush_i) begin
      r_head  <= {IDX_W{1'b0}};
      r_tail  <= {IDX_W{1'b0}};
      r_count <= {(IDX_W+1){1'b0}};
    end else begin
      r_head  <= r_head + IDX_W'(w_n_cmt_gnt);
      r_tail  <= r_tail + IDX_W'(w_n_enq_gnt);
      r_count <= r_count + (IDX_W+1)'(w_n_enq_gnt) - (IDX_W+1)'(w_n_cmt_gnt);
    end
  end

  // Status outputs straight from the occupancy register.
  always_comb begin
    count_o = r_count;
    full_o  = (r_count == (IDX_W+1)'(DEPTH));
    empty_o = (r_count == (IDX_W+1)'(0));
  end

endmodule
